// File: rtl/mbist_fault_sweeper.sv
// Fault-coverage sequencer: for every fault kind x address it injects the fault, resets the
// memory/controller, runs one MBIST pass and tallies detected, missed and timed-out runs.
module mbist_fault_sweeper #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned FK_FIRST       = 1,
  parameter int unsigned FK_LAST        = 7,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sweep_start,
  input  logic                  sweep_abort,
  output logic                  dut_rst,
  output logic                  fault_enable,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic [2:0]            fault_type,
  output logic [ADDR_WIDTH-1:0] fault_target,
  output logic                  bist_start,
  input  logic                  bist_done,
  input  logic                  bist_fail,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic                  res_valid,
  output logic [2:0]            res_kind,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic                  res_detected,
  output logic                  res_timeout,
  output logic [CNT_WIDTH-1:0]  total_cnt,
  output logic [CNT_WIDTH-1:0]  detect_cnt,
  output logic [CNT_WIDTH-1:0]  timeout_cnt
);

  localparam int unsigned PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PH_W-1:0]       RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]       SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]            KIND_FIRST  = 3'(FK_FIRST);
  localparam logic [2:0]            KIND_LAST   = 3'(FK_LAST);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_START, S_WAIT, S_RECORD, S_NEXT, S_DONE
  } state_t;

  state_t                state_q, state_nxt;
  logic [PH_W-1:0]       phase_q, phase_nxt;
  logic [TMR_W-1:0]      timer_q, timer_nxt;
  logic [2:0]            kind_q, kind_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [2:0]            res_kind_nxt;
  logic [ADDR_WIDTH-1:0] res_addr_nxt;
  logic                  res_det_nxt, res_tmo_nxt;
  logic [CNT_WIDTH-1:0]  total_nxt, detect_nxt, timeout_nxt;
  logic                  abort_rst;
  logic                  run_active;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-state, sweep position and result/counter updates
  always_comb begin
    state_nxt    = state_q;
    phase_nxt    = phase_q;
    timer_nxt    = timer_q;
    kind_nxt     = kind_q;
    addr_nxt     = addr_q;
    res_kind_nxt = res_kind;
    res_addr_nxt = res_addr;
    res_det_nxt  = res_detected;
    res_tmo_nxt  = res_timeout;
    total_nxt    = total_cnt;
    detect_nxt   = detect_cnt;
    timeout_nxt  = timeout_cnt;
    abort_rst    = 1'b0;

    if (sweep_abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_nxt = S_IDLE;
      abort_rst = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (sweep_start) begin
            state_nxt   = S_APPLY;
            phase_nxt   = '0;
            kind_nxt    = KIND_FIRST;
            addr_nxt    = '0;
            total_nxt   = '0;
            detect_nxt  = '0;
            timeout_nxt = '0;
          end
        end
        S_APPLY: begin
          if (phase_q == RST_LAST) begin
            phase_nxt = '0;
            state_nxt = S_SETTLE;
          end else begin
            phase_nxt = phase_q + PH_W'(1);
          end
        end
        S_SETTLE: begin
          if (phase_q == SETTLE_LAST) begin
            phase_nxt = '0;
            state_nxt = S_START;
          end else begin
            phase_nxt = phase_q + PH_W'(1);
          end
        end
        S_START: begin
          timer_nxt = '0;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          // Counters bump on WAIT exit so they already include the run being strobed
          if (bist_done || (timer_q == TMR_LAST)) begin
            state_nxt    = S_RECORD;
            res_kind_nxt = kind_q;
            res_addr_nxt = addr_q;
            res_det_nxt  = bist_done & bist_fail;
            res_tmo_nxt  = ~bist_done;
            total_nxt    = sat_inc(total_cnt);
            if (bist_done && bist_fail) detect_nxt = sat_inc(detect_cnt);
            if (!bist_done) timeout_nxt = sat_inc(timeout_cnt);
          end else begin
            timer_nxt = timer_q + TMR_W'(1);
          end
        end
        S_RECORD: state_nxt = S_NEXT;
        S_NEXT: begin
          phase_nxt = '0;
          if (addr_q != ADDR_MAX) begin
            addr_nxt  = addr_q + ADDR_WIDTH'(1);
            state_nxt = S_APPLY;
          end else if (kind_q != KIND_LAST) begin
            addr_nxt  = '0;
            kind_nxt  = kind_q + 3'(1);
            state_nxt = S_APPLY;
          end else begin
            state_nxt = S_DONE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign run_active = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

  // State, datapath and outputs, all registered from the next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      timer_q      <= '0;
      kind_q       <= KIND_FIRST;
      addr_q       <= '0;
      dut_rst      <= 1'b0;
      fault_enable <= 1'b0;
      fault_addr   <= '0;
      fault_type   <= '0;
      fault_target <= '0;
      bist_start   <= 1'b0;
      sweep_busy   <= 1'b0;
      sweep_done   <= 1'b0;
      res_valid    <= 1'b0;
      res_kind     <= '0;
      res_addr     <= '0;
      res_detected <= 1'b0;
      res_timeout  <= 1'b0;
      total_cnt    <= '0;
      detect_cnt   <= '0;
      timeout_cnt  <= '0;
    end else begin
      state_q      <= state_nxt;
      phase_q      <= phase_nxt;
      timer_q      <= timer_nxt;
      kind_q       <= kind_nxt;
      addr_q       <= addr_nxt;
      dut_rst      <= (state_nxt == S_APPLY) | abort_rst;
      fault_enable <= run_active;
      fault_addr   <= run_active ? addr_nxt : '0;
      fault_type   <= run_active ? kind_nxt : '0;
      fault_target <= run_active ? (addr_nxt ^ ADDR_WIDTH'(1)) : '0;
      bist_start   <= (state_nxt == S_START);
      sweep_busy   <= run_active;
      sweep_done   <= (state_nxt == S_DONE);
      res_valid    <= (state_nxt == S_RECORD);
      res_kind     <= res_kind_nxt;
      res_addr     <= res_addr_nxt;
      res_detected <= res_det_nxt;
      res_timeout  <= res_tmo_nxt;
      total_cnt    <= total_nxt;
      detect_cnt   <= detect_nxt;
      timeout_cnt  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mbist_fault_sweeper.sv
// Bench for mbist_fault_sweeper: behavioural MBIST controller, per-sweep reference queue,
// table of sweep configurations plus abort/reset/restart sequences.
module tb_mbist_fault_sweeper;

  localparam int AW     = 2;
  localparam int NADDR  = 4;
  localparam int FKF    = 1;
  localparam int FKL    = 7;
  localparam int RSTC   = 4;
  localparam int SETC   = 4;
  localparam int TMO    = 50;
  localparam int SATMAX = 15;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sweep_start, sweep_abort, bist_done, bist_fail;
  logic          dut_rst, fault_enable, bist_start, sweep_busy, sweep_done, res_valid;
  logic [AW-1:0] fault_addr, fault_target, res_addr;
  logic [2:0]    fault_type, res_kind;
  logic          res_detected, res_timeout;
  logic [15:0]   total_cnt, detect_cnt, timeout_cnt;

  logic          s_dut_rst, s_fault_enable, s_bist_start, s_sweep_busy, s_sweep_done, s_res_valid;
  logic [AW-1:0] s_fault_addr, s_fault_target, s_res_addr;
  logic [2:0]    s_fault_type, s_res_kind;
  logic          s_res_detected, s_res_timeout;
  logic [3:0]    s_total, s_detect, s_timeout;

  mbist_fault_sweeper #(.ADDR_WIDTH(AW), .FK_FIRST(FKF), .FK_LAST(FKL), .RST_CYCLES(RSTC),
    .SETTLE_CYCLES(SETC), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .dut_rst(dut_rst), .fault_enable(fault_enable), .fault_addr(fault_addr),
    .fault_type(fault_type), .fault_target(fault_target), .bist_start(bist_start),
    .bist_done(bist_done), .bist_fail(bist_fail), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .res_valid(res_valid), .res_kind(res_kind), .res_addr(res_addr),
    .res_detected(res_detected), .res_timeout(res_timeout), .total_cnt(total_cnt),
    .detect_cnt(detect_cnt), .timeout_cnt(timeout_cnt));

  // Narrow-counter twin, fed identically, to exercise counter saturation
  mbist_fault_sweeper #(.ADDR_WIDTH(AW), .FK_FIRST(FKF), .FK_LAST(FKL), .RST_CYCLES(RSTC),
    .SETTLE_CYCLES(SETC), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .dut_rst(s_dut_rst), .fault_enable(s_fault_enable), .fault_addr(s_fault_addr),
    .fault_type(s_fault_type), .fault_target(s_fault_target), .bist_start(s_bist_start),
    .bist_done(bist_done), .bist_fail(bist_fail), .sweep_busy(s_sweep_busy),
    .sweep_done(s_sweep_done), .res_valid(s_res_valid), .res_kind(s_res_kind),
    .res_addr(s_res_addr), .res_detected(s_res_detected), .res_timeout(s_res_timeout),
    .total_cnt(s_total), .detect_cnt(s_detect), .timeout_cnt(s_timeout));

  typedef struct {
    int mode;        // 0 all fail, 1 odd addr fails, 2 none fail, 3 random
    int never_kind;  // kind whose runs never complete (0 = none)
    int lat;         // controller latency, -1 = random per run
    int exp_total;
    int exp_detect;  // -1 = take from reference model
    int exp_timeout;
  } sweep_vec_t;

  typedef struct {
    int kind;
    int addr;
    bit det;
    bit tmo;
  } run_t;

  sweep_vec_t vecs [7];
  run_t       exp_q [$];
  bit         fail_tab [0:7][0:NADDR-1];
  int         lat_tab  [0:7][0:NADDR-1];
  int         never_kind = 0;
  int         e_total, e_det, e_tmo;
  int         n_cmp = 0;
  int         n_fail = 0;

  // Behavioural controller: done is a level held until the next start
  logic [2:0]    mdl_kind;
  logic [AW-1:0] mdl_addr;
  int            mdl_cnt;
  bit            mdl_armed;

  always @(posedge clk) begin
    if (reset) begin
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      mdl_armed <= 1'b0;
      mdl_cnt   <= 0;
    end else if (bist_start) begin
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      mdl_armed <= 1'b1;
      mdl_cnt   <= 0;
      mdl_kind  <= fault_type;
      mdl_addr  <= fault_addr;
    end else if (mdl_armed && int'(mdl_kind) != never_kind) begin
      if (mdl_cnt == lat_tab[mdl_kind][mdl_addr]) begin
        bist_done <= 1'b1;
        bist_fail <= fail_tab[mdl_kind][mdl_addr];
        mdl_armed <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit any_out();
    return |{dut_rst, fault_enable, fault_addr, fault_type, fault_target, bist_start,
             sweep_busy, sweep_done, res_valid, res_kind, res_addr, res_detected,
             res_timeout, total_cnt, detect_cnt, timeout_cnt, s_total, s_detect, s_timeout};
  endfunction

  function automatic int sat(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  // Reference: expected kind-major / address-minor run list and totals
  task automatic setup_model(input sweep_vec_t v);
    run_t r;
    int   det = 0;
    int   tmo = 0;
    exp_q.delete();
    never_kind = v.never_kind;
    for (int k = FKF; k <= FKL; k++) begin
      for (int a = 0; a < NADDR; a++) begin
        case (v.mode)
          0:       fail_tab[k][a] = 1'b1;
          1:       fail_tab[k][a] = bit'(a % 2);
          2:       fail_tab[k][a] = 1'b0;
          default: fail_tab[k][a] = bit'($urandom_range(0, 1));
        endcase
        lat_tab[k][a] = (v.lat < 0) ? int'($urandom_range(0, 20)) : v.lat;
        r.kind = k;
        r.addr = a;
        r.tmo  = (k == v.never_kind);
        r.det  = !r.tmo && fail_tab[k][a];
        exp_q.push_back(r);
        det += int'(r.det);
        tmo += int'(r.tmo);
      end
    end
    e_total = v.exp_total;
    e_det   = (v.exp_detect < 0) ? det : v.exp_detect;
    e_tmo   = v.exp_timeout;
  endtask

  task automatic run_sweep(input int abort_after, input bit poke);
    int   cyc = 0;
    int   rst_run = 0;
    int   rst_fall = 0;
    int   start_cyc = 0;
    int   pulses = 0;
    int   nstrobe = 0;
    bit   seen = 0;
    bit   poked = 0;
    bit   noisy = 0;
    run_t e;

    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    check("accept_busy", sweep_busy, 1);
    check("accept_counters_cleared", total_cnt, 0);
    check("accept_kind", fault_type, FKF);
    check("accept_addr", fault_addr, 0);

    while (cyc < BUDGET) begin
      if (cyc > 0) @(negedge clk);
      sweep_start = 1'b0;
      if (sweep_done) break;

      if (dut_rst) rst_run++;
      else if (rst_run > 0) begin
        check("dut_rst_len", rst_run, RSTC);
        rst_run  = 0;
        rst_fall = cyc;
      end
      if (bist_start) begin
        pulses++;
        if (!seen) begin
          check("settle_gap", cyc - rst_fall, SETC);
          start_cyc = cyc;
          seen      = 1'b1;
        end
      end
      if (res_valid) begin
        if (exp_q.size() == 0) check("extra_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_kind", res_kind, e.kind);
          check("res_addr", res_addr, e.addr);
          check("res_detected", res_detected, e.det);
          check("res_timeout", res_timeout, e.tmo);
          check("fault_addr_held", fault_addr, e.addr);
          check("fault_type_held", fault_type, e.kind);
          check("fault_target", fault_target, fault_addr ^ 2'b01);
          check("fault_enable_run", fault_enable, 1);
          check("wait_cycles", cyc - start_cyc - 1, e.tmo ? TMO : lat_tab[e.kind][e.addr] + 2);
        end
        check("start_pulse_count", pulses, 1);
        pulses = 0;
        seen   = 1'b0;
        nstrobe++;
      end

      if (poke && seen && !poked && cyc > start_cyc) begin
        sweep_start = 1'b1;
        poked       = 1'b1;
      end

      if (abort_after >= 0 && nstrobe == abort_after && seen && cyc > start_cyc && bist_done) begin
        sweep_abort = 1'b1;
        @(negedge clk); sweep_abort = 1'b0;
        check("abort_busy", sweep_busy, 0);
        check("abort_fault_enable", fault_enable, 0);
        check("abort_dut_rst", dut_rst, 1);
        check("abort_no_strobe", res_valid, 0);
        check("abort_total", total_cnt, abort_after);
        @(negedge clk);
        check("abort_dut_rst_release", dut_rst, 0);
        repeat (30) begin
          @(negedge clk);
          if (res_valid || sweep_busy || bist_start) noisy = 1'b1;
        end
        check("abort_quiet", noisy, 0);
        check("abort_total_held", total_cnt, abort_after);
        return;
      end
      cyc++;
    end

    if (cyc >= BUDGET) begin
      check("sweep_finished_in_budget", 0, 1);
      return;
    end
    check("strobes", nstrobe, e_total);
    check("leftover_runs", exp_q.size(), 0);
    check("total_cnt", total_cnt, e_total);
    check("detect_cnt", detect_cnt, e_det);
    check("timeout_cnt", timeout_cnt, e_tmo);
    check("done_busy", sweep_busy, 0);
    check("done_fault_enable", fault_enable, 0);
    check("sat_total", s_total, sat(e_total));
    check("sat_detect", s_detect, sat(e_det));
    check("sat_timeout", s_timeout, sat(e_tmo));
  endtask

  initial begin
    int wait_cyc;
    vecs[0] = '{0, 0,  8, 28, 28, 0};
    vecs[1] = '{1, 0,  8, 28, 14, 0};
    vecs[2] = '{0, 3,  8, 28, 24, 4};
    vecs[3] = '{1, 5, -1, 28, 12, 4};
    vecs[4] = '{2, 0, -1, 28,  0, 0};
    vecs[5] = '{3, 0, -1, 28, -1, 0};
    vecs[6] = '{3, 6, -1, 28, -1, 4};

    reset = 1'b1; sweep_start = 1'b0; sweep_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", any_out(), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      setup_model(vecs[i]);
      run_sweep(-1, i == 1);
    end

    // Abort during WAIT with done arriving in the same cycle, then clean restart
    setup_model(vecs[0]);
    run_sweep(5, 1'b0);
    setup_model(vecs[0]);
    run_sweep(-1, 1'b0);

    // Reset while in SETTLE
    @(negedge clk); sweep_start = 1'b1;
    @(negedge clk); sweep_start = 1'b0;
    wait_cyc = 0;
    while (!(fault_enable && !dut_rst) && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reached_settle", wait_cyc < 100, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midsweep_reset_outputs_zero", any_out(), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_idle", sweep_busy, 0);

    setup_model(vecs[5]);
    run_sweep(-1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mbist_fault_sweeper.md
Name: mbist_fault_sweeper

Overview:
- Hardware fault-coverage sequencer that sits directly upstream of the sram_wrapper fault-injection port and the mbist_controller start/done interface.
- For every fault kind in a range and every memory address, it:
  - programs the injected fault;
  - resets the memory and controller;
  - pulses start and waits for completion;
  - tallies detected, missed and timed-out runs.
- Gives on-chip/emulation coverage runs without a simulator-driven loop.

Parameters:
- ADDR_WIDTH, 8, memory address width; addresses swept 0 .. 2^ADDR_WIDTH-1.
- FK_FIRST, 1, first fault kind swept (3-bit encoding, 0 = none).
- FK_LAST, 7, last fault kind swept, inclusive; requires FK_FIRST <= FK_LAST.
- RST_CYCLES, 4, cycles dut_rst is held per run.
- SETTLE_CYCLES, 4, idle cycles between dut_rst release and bist_start.
- TIMEOUT_CYCLES, 200000, max WAIT cycles per run before declaring timeout.
- CNT_WIDTH, 16, width of the result counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sweep_start  in  1  begin a sweep; sampled only in IDLE/DONE.
- sweep_abort  in  1  abandon the current sweep.
- dut_rst  out  1  active-high reset to the memory and controller; the top level inverts it to their reset_n.
- fault_enable  out  1  fault injection enable.
- fault_addr  out  ADDR_WIDTH  faulty cell address.
- fault_type  out  3  fault kind.
- fault_target  out  ADDR_WIDTH  aggressor/victim address; always fault_addr ^ 1.
- bist_start  out  1  one-cycle start pulse to the controller.
- bist_done  in  1  controller test_done, a level.
- bist_fail  in  1  controller fail_flag; valid while bist_done is high.
- sweep_busy  out  1  high from sweep accept to DONE.
- sweep_done  out  1  high in DONE.
- res_valid  out  1  one-cycle strobe per completed run.
- res_kind  out  3  fault kind of the strobed run.
- res_addr  out  ADDR_WIDTH  address of the strobed run.
- res_detected  out  1  run detected the fault.
- res_timeout  out  1  run timed out.
- total_cnt  out  CNT_WIDTH  runs completed.
- detect_cnt  out  CNT_WIDTH  runs detected.
- timeout_cnt  out  CNT_WIDTH  runs timed out.

Behaviour:
- Reset: every output is 0, the state is IDLE, and the kind/address registers are loaded with FK_FIRST/0. This applies equally when reset is asserted mid-sweep; no partial result is strobed.
- States: IDLE, APPLY, SETTLE, START, WAIT, RECORD, NEXT, DONE.
- IDLE/DONE + sweep_start:
  - clear all counters;
  - set kind = FK_FIRST, addr = 0;
  - enter APPLY.
- sweep_start in any other state is ignored.
- APPLY:
  - fault_enable = 1; fault_addr/fault_type/fault_target driven from the registers;
  - dut_rst = 1 for exactly RST_CYCLES cycles, then SETTLE.
- Fault outputs are stable from APPLY through RECORD of the same run.
- SETTLE: dut_rst = 0 for SETTLE_CYCLES cycles, then START.
- START: bist_start = 1 for exactly one cycle, then WAIT with the timer cleared.
- WAIT:
  - bist_done high -> capture detected = bist_fail, timeout = 0; go to RECORD.
  - No bist_done and timer == TIMEOUT_CYCLES-1 -> detected = 0, timeout = 1; go to RECORD.
  - bist_done is not sampled outside WAIT.
- RECORD (one cycle):
  - res_valid = 1 with res_kind/res_addr/res_detected/res_timeout;
  - total_cnt +1; detect_cnt +1 if detected; timeout_cnt +1 if timeout;
  - all counters saturate at 2^CNT_WIDTH-1;
  - go to NEXT.
- NEXT (one cycle):
  - addr < max -> addr+1, go to APPLY;
  - else addr = 0 and kind < FK_LAST -> kind+1, go to APPLY;
  - else go to DONE.
- DONE:
  - sweep_done = 1, sweep_busy = 0, fault_enable = 0;
  - counters held until the next accepted sweep_start.
- sweep_abort (any state except IDLE/DONE):
  - next state IDLE;
  - fault_enable = 0, dut_rst = 1 for one cycle, then 0;
  - counters hold their partial values; no res_valid.
- Simultaneous events:
  - abort wins over bist_done and timeout in the same cycle;
  - reset wins over everything.
- Per-run latency: RST_CYCLES + SETTLE_CYCLES + 1 + WAIT cycles + 2.
- Expected final total_cnt = (FK_LAST-FK_FIRST+1) * 2^ADDR_WIDTH; 1792 at defaults.

Test Plan:
1. ADDR_WIDTH=2, FK 1..7, behavioural controller raising done 10 cycles after start with fail=1 -> 28 res_valid strobes in kind-major/address-minor order (1/0, 1/1 … 7/3); total=28, detect=28, timeout=0; sweep_done=1.
2. Same setup, model fails only when fault_addr is odd -> detect_cnt=14; res_detected matches parity every run; fault_target = fault_addr^1 on every run.
3. TIMEOUT_CYCLES=50, model never raises done for kind 3 -> timeout_cnt=4, detect_cnt=24; each of those four runs ends exactly 50 WAIT cycles after its START.
4. Check dut_rst high exactly RST_CYCLES cycles; bist_start a single pulse exactly SETTLE_CYCLES after dut_rst falls; a done held high from a previous run is not sampled during APPLY/SETTLE.
5. Assert sweep_abort during WAIT of run 5 -> IDLE next cycle, fault_enable=0, total_cnt=5, no further strobes; a new sweep_start restarts from kind 1/addr 0 with counters cleared.
6. Assert reset mid-SETTLE -> all outputs 0 on the next edge; sweep_start pulsed during WAIT is ignored.
